a0_uart_tx: RTL and testbench

Serial output stage downstream of the CPU top level. It watches the register-file `a0` output and captures every change into a small FIFO. Each captured word goes out on a single UART TX line as four 8N1 bytes, least-significant byte first. This lets test programs stream results off-chip without stalling the core.

---
 rtl/a0_uart_pkg.sv | 15 +
 rtl/sync_fifo.sv | 48 ++++
 rtl/a0_uart_tx.sv | 147 ++++++++++++++
 tb/tb_a0_uart_tx.sv | 446 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/a0_uart_pkg.sv
// a0_uart_tx shared types and framing constants.
// Word framing: four 8N1 bytes, LSB first.
package a0_uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_e;

  localparam int BITS_PER_BYTE  = 8;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with show-ahead read.
// Callers gate push on !full and pop on !empty.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] rdata
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [AW:0]      count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= wdata;
  end

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign rdata = mem_q[rptr_q];

endmodule

// File: rtl/a0_uart_tx.sv
// Streams every change of the CPU a0 register out of a UART TX line,
// buffered through a small FIFO, as four 8N1 bytes LSB first.
module a0_uart_tx
  import a0_uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] a0,
  output logic                  tx,
  output logic                  busy,
  output logic                  overflow
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    BIT_LAST  = 3'(BITS_PER_BYTE - 1);
  localparam logic [1:0]    BYTE_LAST = 2'(BYTES_PER_WORD - 1);

  uart_state_e           state_q, state_d;
  logic [CW-1:0]         baud_q, baud_d;
  logic [2:0]            bit_q, bit_d;
  logic [1:0]            byte_q, byte_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [DATA_WIDTH-1:0] a0_prev_q;
  logic                  tx_q, tx_d;
  logic                  ovf_q, ovf_d;

  logic                  change;
  logic                  push;
  logic                  pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic                  baud_end;
  logic [BITS_PER_BYTE-1:0] cur_byte;

  // Full is the start-of-cycle view, so a same-cycle pop never rescues a push.
  assign change = (a0 != a0_prev_q);
  assign push   = change & ~fifo_full;
  assign ovf_d  = ovf_q | (change & fifo_full);

  sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (a0),
    .full  (fifo_full),
    .empty (fifo_empty),
    .rdata (fifo_rdata)
  );

  assign baud_end = (baud_q == BAUD_LAST);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + 1'b1;
    bit_d   = bit_q;
    byte_d  = byte_q;
    shreg_d = shreg_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        baud_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shreg_d = fifo_rdata;
          byte_d  = '0;
          state_d = START;
        end
      end
      START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == BIT_LAST) state_d = STOP;
          else                   bit_d   = bit_q + 1'b1;
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (byte_q == BYTE_LAST) begin
            state_d = IDLE;
          end else begin
            byte_d  = byte_q + 1'b1;
            shreg_d = shreg_q >> BITS_PER_BYTE;
            state_d = START;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level is computed from the next state so tx leaves a flop.
  assign cur_byte = shreg_d[BITS_PER_BYTE-1:0];

  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = cur_byte[bit_d];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_q     <= '0;
      byte_q    <= '0;
      shreg_q   <= '0;
      a0_prev_q <= '0;
      tx_q      <= 1'b1;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      shreg_q   <= shreg_d;
      a0_prev_q <= a0;
      tx_q      <= tx_d;
      ovf_q     <= ovf_d;
    end
  end

  assign tx       = tx_q;
  assign overflow = ovf_q;
  assign busy     = (state_q != IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_a0_uart_tx.sv
// Bench for a0_uart_tx: cycle-level reference model of the line plus
// an independent UART receiver that decodes words from tx.
module tb_a0_uart_tx;

  localparam int CPB    = 4;
  localparam int BYTE_T = 10 * CPB;
  localparam int WORD_T = 4 * BYTE_T;
  localparam int DEPTH  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] a0  = '0;
  logic        tx;
  logic        busy;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  a0_uart_tx #(
    .DATA_WIDTH   (32),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .a0       (a0),
    .tx       (tx),
    .busy     (busy),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of pending words and a transmit slot
  // that is occupied for WORD_T cycles plus one idle cycle.
  int          n = 0;
  logic [31:0] m_prev;
  logic [31:0] m_q[$];
  logic [31:0] m_sent[$];
  logic [31:0] m_cur;
  logic [31:0] m_bv;
  int          m_pop_t;
  int          m_next_pop = 0;
  int          m_k, m_slot, m_pos;
  bit          m_active = 0;
  bit          m_full;
  bit          m_ovf = 0;
  logic        exp_tx = 1'b1;
  logic        exp_busy = 1'b0;

  always @(posedge clk) begin
    n++;
    if (rst) begin
      m_q.delete();
      m_sent.delete();
      m_prev     = '0;
      m_ovf      = 0;
      m_active   = 0;
      m_next_pop = 0;
    end else begin
      m_full = (m_q.size() == DEPTH);
      if (m_active && (n - m_pop_t) >= WORD_T) m_active = 0;
      if (!m_active && n >= m_next_pop && m_q.size() > 0) begin
        m_cur = m_q.pop_front();
        m_sent.push_back(m_cur);
        m_pop_t    = n;
        m_active   = 1;
        m_next_pop = n + WORD_T + 1;
      end
      if (a0 !== m_prev) begin
        if (m_full) m_ovf = 1;
        else        m_q.push_back(a0);
      end
      m_prev = a0;
    end
    exp_tx = 1'b1;
    if (m_active) begin
      m_k    = n - m_pop_t;
      m_slot = m_k / BYTE_T;
      m_pos  = (m_k % BYTE_T) / CPB;
      m_bv   = m_cur >> (8 * m_slot);
      if (m_pos == 0)      exp_tx = 1'b0;
      else if (m_pos == 9) exp_tx = 1'b1;
      else                 exp_tx = m_bv[m_pos-1];
    end
    exp_busy = m_active || (m_q.size() != 0);
  end

  // Independent receiver: mid-bit sampling of tx, bytes assembled LSB first.
  logic [31:0] rx_words[$];
  int          rx_start[$];
  bit          rx_clr = 0;
  bit          rx_on = 0;
  int          rx_cnt;
  int          rx_nb = 0;
  int          rx_wstart;
  int          cyc = 0;
  logic [7:0]  rx_byte;
  logic [31:0] rx_word;

  always @(posedge clk) if (rst) rx_clr = 1;

  always @(negedge clk) begin
    cyc++;
    if (rx_clr) begin
      rx_clr = 0;
      rx_on  = 0;
      rx_nb  = 0;
      rx_words.delete();
      rx_start.delete();
    end else if (!rx_on) begin
      if (tx === 1'b0) begin
        rx_on  = 1;
        rx_cnt = 0;
        if (rx_nb == 0) rx_wstart = cyc;
      end
    end else begin
      rx_cnt++;
      if ((rx_cnt % CPB) == CPB / 2 && rx_cnt / CPB >= 1 && rx_cnt / CPB <= 8)
        rx_byte[rx_cnt/CPB-1] = tx;
      if (rx_cnt == BYTE_T - 1) begin
        rx_on = 0;
        rx_word[8*rx_nb +: 8] = rx_byte;
        rx_nb++;
        if (rx_nb == 4) begin
          rx_words.push_back(rx_word);
          rx_start.push_back(rx_wstart);
          rx_nb = 0;
        end
      end
    end
  end

  task automatic apply_reset();
    rst = 1'b1;
    a0  = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    repeat (200) begin
      @(negedge clk);
      checks++;
      if ({tx, busy, overflow} !== 3'b100) begin
        errors++;
        $display("FAIL reset_idle: tx/busy/ovf=%b want 100", {tx, busy, overflow});
      end
    end
    checks++;
    if (rx_words.size() != 0) begin
      errors++;
      $display("FAIL reset_no_frame: words=%0d want 0", rx_words.size());
    end
  endtask

  task automatic test_single_word();
    logic [7:0]  exp_b [4];
    logic [31:0] w;
    int fall;
    logic b_last, b_after;
    exp_b = '{8'h78, 8'h56, 8'h34, 8'h12};
    fall = -1;
    b_last = 1'bx;
    b_after = 1'bx;
    apply_reset();
    @(negedge clk);
    a0 = 32'h1234_5678;
    for (int c = 1; c <= WORD_T + 20; c++) begin
      @(negedge clk);
      checks++;
      if ({tx, busy, overflow} !== {exp_tx, exp_busy, m_ovf}) begin
        errors++;
        $display("FAIL single_line c=%0d: got %b want %b", c,
                 {tx, busy, overflow}, {exp_tx, exp_busy, m_ovf});
      end
      if (fall < 0 && tx === 1'b0) fall = c;
      if (fall > 0 && c == fall + WORD_T - 1) b_last = busy;
      if (fall > 0 && c == fall + WORD_T) b_after = busy;
    end
    checks++;
    if (fall != 2) begin
      errors++;
      $display("FAIL single_latency: got %0d want 2", fall);
    end
    checks++;
    if (b_last !== 1'b1 || b_after !== 1'b0) begin
      errors++;
      $display("FAIL single_duration: busy end=%b,%b want 1,0", b_last, b_after);
    end
    checks++;
    if (rx_words.size() != 1) begin
      errors++;
      $display("FAIL single_count: got %0d want 1", rx_words.size());
    end else begin
      w = rx_words[0];
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (w[8*i +: 8] !== exp_b[i]) begin
          errors++;
          $display("FAIL single_byte%0d: got %h want %h", i, w[8*i +: 8], exp_b[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [3];
    vals = '{32'hA, 32'hB, 32'hC};
    apply_reset();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      a0 = vals[i];
      @(negedge clk);
    end
    repeat (3 * (WORD_T + 1) + 20) begin
      @(negedge clk);
      checks++;
      if ({tx, busy, overflow} !== {exp_tx, exp_busy, m_ovf}) begin
        errors++;
        $display("FAIL b2b_line: got %b want %b", {tx, busy, overflow},
                 {exp_tx, exp_busy, m_ovf});
      end
    end
    checks++;
    if (rx_words.size() != 3) begin
      errors++;
      $display("FAIL b2b_count: got %0d want 3", rx_words.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (rx_words[i] !== vals[i]) begin
          errors++;
          $display("FAIL b2b_word%0d: got %h want %h", i, rx_words[i], vals[i]);
        end
      end
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (rx_start[i] - rx_start[i-1] != WORD_T + 1) begin
          errors++;
          $display("FAIL b2b_gap%0d: got %0d want %0d", i,
                   rx_start[i] - rx_start[i-1], WORD_T + 1);
        end
      end
    end
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ovf: got %b want 0", overflow);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] vals [6];
    logic [31:0] prev;
    bit dropped_sticky;
    prev = '0;
    for (int i = 0; i < 6; i++) begin
      vals[i] = $urandom;
      while (vals[i] == prev) vals[i] = $urandom;
      prev = vals[i];
    end
    apply_reset();
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      a0 = vals[i];
      @(negedge clk);
    end
    dropped_sticky = 1;
    repeat (5 * (WORD_T + 1) + 20) begin
      @(negedge clk);
      if (overflow !== 1'b1) dropped_sticky = 0;
      checks++;
      if ({tx, busy, overflow} !== {exp_tx, exp_busy, m_ovf}) begin
        errors++;
        $display("FAIL ovf_line: got %b want %b", {tx, busy, overflow},
                 {exp_tx, exp_busy, m_ovf});
      end
    end
    checks++;
    if (!dropped_sticky) begin
      errors++;
      $display("FAIL ovf_sticky: overflow dropped low, want held 1");
    end
    checks++;
    if (rx_words.size() != 5) begin
      errors++;
      $display("FAIL ovf_count: got %0d want 5", rx_words.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (rx_words[i] !== vals[i]) begin
          errors++;
          $display("FAIL ovf_word%0d: got %h want %h", i, rx_words[i], vals[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] v;
    int c;
    v = $urandom | 32'h1;
    apply_reset();
    @(negedge clk);
    a0 = v;
    c = 0;
    while (tx !== 1'b0 && c < 10) begin
      @(negedge clk);
      c++;
    end
    checks++;
    if (c != 2) begin
      errors++;
      $display("FAIL mid_first_start: got %0d want 2", c);
    end
    repeat (BYTE_T + 10) begin
      @(negedge clk);
      checks++;
      if ({tx, busy} !== {exp_tx, exp_busy}) begin
        errors++;
        $display("FAIL mid_line: got %b want %b", {tx, busy}, {exp_tx, exp_busy});
      end
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({tx, busy, overflow} !== 3'b100) begin
      errors++;
      $display("FAIL mid_after_rst: got %b want 100", {tx, busy, overflow});
    end
    @(negedge clk);
    checks++;
    if (tx !== 1'b1) begin
      errors++;
      $display("FAIL mid_restart_early: tx=%b want 1", tx);
    end
    @(negedge clk);
    checks++;
    if (tx !== 1'b0) begin
      errors++;
      $display("FAIL mid_restart: tx=%b want 0", tx);
    end
    repeat (WORD_T + 10) begin
      @(negedge clk);
      checks++;
      if ({tx, busy, overflow} !== {exp_tx, exp_busy, m_ovf}) begin
        errors++;
        $display("FAIL mid_resend_line: got %b want %b", {tx, busy, overflow},
                 {exp_tx, exp_busy, m_ovf});
      end
    end
    checks++;
    if (rx_words.size() != 1 || rx_words[0] !== v) begin
      errors++;
      $display("FAIL mid_resend_word: got n=%0d w=%h want n=1 w=%h",
               rx_words.size(), rx_words.size() > 0 ? rx_words[0] : 32'h0, v);
    end
  endtask

  task automatic test_steady_value();
    apply_reset();
    @(negedge clk);
    a0 = 32'h55;
    repeat (500) begin
      @(negedge clk);
      checks++;
      if ({tx, busy, overflow} !== {exp_tx, exp_busy, m_ovf}) begin
        errors++;
        $display("FAIL steady_line: got %b want %b", {tx, busy, overflow},
                 {exp_tx, exp_busy, m_ovf});
      end
    end
    checks++;
    if (rx_words.size() != 1 || rx_words[0] !== 32'h55) begin
      errors++;
      $display("FAIL steady_once: got n=%0d w=%h want n=1 w=00000055",
               rx_words.size(), rx_words.size() > 0 ? rx_words[0] : 32'h0);
    end
  endtask

  task automatic test_random();
    int burst;
    burst = 0;
    apply_reset();
    for (int c = 0; c < 4000; c++) begin
      if (burst > 0) begin
        a0 = $urandom;
        burst--;
      end else if ($urandom_range(0, 199) == 0) begin
        burst = $urandom_range(1, 7);
      end
      @(negedge clk);
      checks++;
      if ({tx, busy, overflow} !== {exp_tx, exp_busy, m_ovf}) begin
        errors++;
        $display("FAIL rand_line c=%0d: got %b want %b", c, {tx, busy, overflow},
                 {exp_tx, exp_busy, m_ovf});
      end
    end
    repeat (5 * (WORD_T + 1) + 10) begin
      @(negedge clk);
      checks++;
      if ({tx, busy, overflow} !== {exp_tx, exp_busy, m_ovf}) begin
        errors++;
        $display("FAIL rand_drain: got %b want %b", {tx, busy, overflow},
                 {exp_tx, exp_busy, m_ovf});
      end
    end
    checks++;
    if (rx_words.size() != m_sent.size()) begin
      errors++;
      $display("FAIL rand_count: got %0d want %0d", rx_words.size(), m_sent.size());
    end else begin
      foreach (m_sent[i]) begin
        checks++;
        if (rx_words[i] !== m_sent[i]) begin
          errors++;
          $display("FAIL rand_word%0d: got %h want %h", i, rx_words[i], m_sent[i]);
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_overflow();
    test_reset_mid_frame();
    test_steady_value();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
